mem_access_ctl: RTL and testbench
=================================

Name: mem_access_ctl

Overview:
- Data-memory access stage fed directly by the 16-bit memory-address select mux.
- On a start pulse from ctrl, captures the selected 16-bit address (and store data or load intent) into a memory address register (MAR).
- Runs a req/ack handshake with data memory and latches load data into a 32-bit memory data register (MDR) for the register-file write-back path.
- Provides done/busy/err status to the control FSM.

Parameters:
- TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before the access is aborted; legal range 1..65535.
- CNT_W, 16, width of the internal wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst_f  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request from ctrl to begin an access.
- wr_en  input  1  1 = store, 0 = load; sampled with start.
- addr_in  input  16  address from the memory-address select mux; sampled with start.
- wdata  input  32  store data (register-file rsb); sampled with start.
- mem_addr  output  16  MAR contents driven to data memory.
- mem_wdata  output  32  captured store data.
- mem_req  output  1  access request to memory.
- mem_we  output  1  write strobe; valid while mem_req=1.
- mem_ack  input  1  memory completion; rdata valid in the same cycle for loads.
- mem_rdata  input  32  load data from memory.
- mdr  output  32  memory data register.
- busy  output  1  high in any non-IDLE state.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  one-cycle pulse on timeout abort.

Behaviour:
- All outputs are registered.
- Reset (rst_f=0, asynchronous, effective immediately, including mid-access):
  - state=IDLE.
  - mem_addr=0, mem_wdata=0, mdr=0, counter=0.
  - mem_req=0, mem_we=0, busy=0, done=0, err=0.
  - An in-flight access is dropped with no completion or error pulse.
- States: IDLE, REQ, DONE, ERR.
- IDLE:
  - start=1 captures addr_in→MAR, wdata→mem_wdata and wr_en→mem_we, clears the counter, then goes to REQ.
  - start=0 stays in IDLE.
  - mem_ack while in IDLE is ignored.
- REQ:
  - mem_req=1; mem_addr, mem_wdata and mem_we are held stable for the whole state.
  - mem_ack=1 at the edge:
    - load: mdr<=mem_rdata; store: mdr unchanged.
    - Go to DONE.
  - No ack and counter==TIMEOUT-1: go to ERR.
  - No ack otherwise: counter+1, stay in REQ.
  - mem_ack on the final allowed cycle wins over timeout.
- DONE: done=1, mem_req=0 for one cycle, then IDLE.
- ERR:
  - err=1, mem_req=0 for one cycle, then IDLE.
  - mdr and MAR keep their prior values.
- start outside IDLE is ignored: no queuing and no MAR update.
  - start is accepted again in the cycle after DONE/ERR, i.e. once back in IDLE.
- Latency:
  - Start sampled at edge n → mem_req high in cycle n+1.
  - Ack sampled at edge n+1+k → done high in cycle n+2+k.
  - Minimum start-to-done is 2 cycles.
  - A timeout aborts after exactly TIMEOUT cycles of mem_req.
- busy=1 in REQ, DONE and ERR.
- MAR is never modified by addr_in changes outside a start in IDLE; a mux select change mid-access has no effect.

Test Plan:
- Zero-wait load: start, wr_en=0, addr_in=0x00A4, mem_ack high in the first REQ cycle with rdata=0xDEADBEEF -> mem_req for 1 cycle, mem_addr=0x00A4, mem_we=0, done 2 cycles after start, mdr=0xDEADBEEF.
- 3-wait store: start, wr_en=1, addr_in=0x1234, wdata=0x0000CAFE, ack after 3 REQ cycles -> mem_req high 4 cycles, mem_we=1, mem_wdata=0x0000CAFE, mdr unchanged, done once.
- Timeout with TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, err pulse, done never asserts, mdr keeps previous value, next start accepted.
- Ack on the last allowed cycle (TIMEOUT=4, ack in the 4th REQ cycle) -> done, no err.
- start=1 and addr_in=0xFFFF toggled during REQ -> ignored; MAR stays at its original value and only one done pulse occurs.
- rst_f low mid-REQ -> mem_req, busy and mdr go to 0 immediately, no done or err; an access after reset release completes normally.

Source files
------------

// File: rtl/mem_access_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_ctl                                                             |
// | Data-memory access stage: MAR/MDR capture, req/ack handshake, timeout.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_access_ctl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        start,
  input  logic        wr_en,
  input  logic [15:0] addr_in,
  input  logic [31:0] wdata,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mdr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_mar;
  logic [31:0]      r_wdata;
  logic [31:0]      r_mdr;
  logic             r_we;
  logic             r_req;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             w_accept;

  assign w_accept = (r_state == S_IDLE) && start;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_REQ;
      S_REQ: begin
        // An ack on the final allowed cycle takes priority over the timeout.
        if (mem_ack)                  w_state_nxt = S_DONE;
        else if (r_cnt == C_CNT_LAST) w_state_nxt = S_ERR;
      end
      S_DONE: w_state_nxt = S_IDLE;
      S_ERR:  w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered
  // yet line up with the state they describe.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == S_REQ);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      r_err   <= (w_state_nxt == S_ERR);
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_mar   <= 16'd0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
      r_mdr   <= 32'd0;
    end else begin
      if (w_accept) begin
        r_mar   <= addr_in;
        r_wdata <= wdata;
        r_we    <= wr_en;
        r_cnt   <= '0;
      end else if ((r_state == S_REQ) && !mem_ack && (r_cnt != C_CNT_LAST)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_state == S_REQ) && mem_ack && !r_we) begin
        r_mdr <= mem_rdata;
      end
    end
  end

  assign mem_addr  = r_mar;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_we;
  assign mem_req   = r_req;
  assign mdr       = r_mdr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_access_ctl                                                          |
// | Self-checking bench for mem_access_ctl against a transaction-level model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_access_ctl;

  localparam int C_TMO = 4;

  logic        clk;
  logic        rst_f;
  logic        start;
  logic        wr_en;
  logic [15:0] addr_in;
  logic [31:0] wdata;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] mdr;
  logic        busy;
  logic        done;
  logic        err;

  int          checks;
  int          failures;
  logic [31:0] model_mdr;

  mem_access_ctl #(
    .TIMEOUT (C_TMO),
    .CNT_W   (16)
  ) u_dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .start     (start),
    .wr_en     (wr_en),
    .addr_in   (addr_in),
    .wdata     (wdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mdr       (mdr),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access seen as a transaction: waits = REQ cycles without ack before the
  // ack. If waits >= C_TMO the access times out after C_TMO REQ cycles.
  // abort_at > 0 pulls reset asynchronously in that cycle after start.
  task automatic run_access(input logic wr, input logic [15:0] a, input logic [31:0] d,
                            input int waits, input logic [31:0] rd, input logic noise,
                            input int abort_at);
    bit ok;
    int nreq;
    ok   = (waits < C_TMO);
    nreq = ok ? waits + 1 : C_TMO;
    @(negedge clk);
    start   = 1'b1;
    wr_en   = wr;
    addr_in = a;
    wdata   = d;
    mem_ack = 1'b0;
    for (int cyc = 1; cyc <= nreq + 2; cyc++) begin
      @(negedge clk);
      if (ok && !wr && cyc == nreq + 1) model_mdr = rd;
      check("mem_req",   {31'd0, mem_req}, {31'd0, cyc <= nreq});
      check("busy",      {31'd0, busy},    {31'd0, cyc <= nreq + 1});
      check("done",      {31'd0, done},    {31'd0, ok && cyc == nreq + 1});
      check("err",       {31'd0, err},     {31'd0, !ok && cyc == nreq + 1});
      check("mem_addr",  {16'd0, mem_addr}, {16'd0, a});
      check("mem_wdata", mem_wdata, d);
      if (cyc <= nreq) check("mem_we", {31'd0, mem_we}, {31'd0, wr});
      check("mdr", mdr, model_mdr);
      if (cyc == abort_at) begin
        #2 rst_f = 1'b0;
        #1;
        model_mdr = 32'd0;
        check("rst_mem_req",  {31'd0, mem_req}, 32'd0);
        check("rst_busy",     {31'd0, busy},    32'd0);
        check("rst_mdr",      mdr,              32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        start   = 1'b0;
        mem_ack = 1'b1;
        for (int j = 0; j < 2; j++) begin
          @(negedge clk);
          check("rst_done", {31'd0, done}, 32'd0);
          check("rst_err",  {31'd0, err},  32'd0);
          check("rst_busy_hold", {31'd0, busy}, 32'd0);
        end
        rst_f   = 1'b1;
        mem_ack = 1'b0;
        return;
      end
      // Disturb inputs that must be ignored mid-access.
      start   = noise && (cyc <= nreq);
      addr_in = noise ? 16'hFFFF : 16'($urandom);
      wdata   = $urandom;
      wr_en   = ~wr;
      if (cyc <= nreq) begin
        mem_ack   = ok && (cyc == nreq);
        mem_rdata = mem_ack ? rd : $urandom;
      end else begin
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
      end
    end
    start   = 1'b0;
    mem_ack = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    model_mdr = 32'd0;
    rst_f     = 1'b0;
    start     = 1'b0;
    wr_en     = 1'b0;
    addr_in   = 16'd0;
    wdata     = 32'd0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    #1;
    check("reset_mem_addr",  {16'd0, mem_addr}, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    check("reset_mdr",       mdr, 32'd0);
    check("reset_mem_req",   {31'd0, mem_req}, 32'd0);
    check("reset_mem_we",    {31'd0, mem_we}, 32'd0);
    check("reset_busy",      {31'd0, busy}, 32'd0);
    check("reset_done",      {31'd0, done}, 32'd0);
    check("reset_err",       {31'd0, err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_f = 1'b1;

    // Zero-wait load.
    run_access(1'b0, 16'h00A4, 32'h0, 0, 32'hDEADBEEF, 1'b0, 0);
    // Three-wait store, mdr must keep DEADBEEF.
    run_access(1'b1, 16'h1234, 32'h0000CAFE, 3, 32'h11111111, 1'b0, 0);
    // Timeout, then a following access is accepted.
    run_access(1'b0, 16'h0BAD, 32'h5, 9, 32'h22222222, 1'b0, 0);
    // Ack on the last allowed cycle.
    run_access(1'b0, 16'h0042, 32'h6, C_TMO - 1, 32'h33333333, 1'b0, 0);
    // start/addr_in=FFFF toggled during REQ.
    run_access(1'b0, 16'h0777, 32'h7, 2, 32'h44444444, 1'b1, 0);
    // Reset in the middle of REQ, then a normal access.
    run_access(1'b0, 16'h0888, 32'h8, 9, 32'h55555555, 1'b0, 2);
    run_access(1'b0, 16'h0999, 32'h9, 1, 32'h66666666, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      run_access(1'($urandom), 16'($urandom), $urandom, int'($urandom_range(0, 6)),
                 $urandom, 1'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
